// File: rtl/stdp_scheduler.sv
// Pair-based STDP scheduler for one synapse.
// Tracks cycles since the last pre/post spike, classifies each pairing as
// potentiation or depression, and applies a saturating, decaying update.
module stdp_scheduler #(
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned T_WIDTH   = 4,
  parameter int unsigned WINDOW    = 15,
  parameter int unsigned A_PLUS    = 16,
  parameter int unsigned A_MINUS   = 16,
  parameter int unsigned TAU_SHIFT = 2,
  parameter int unsigned W_INIT    = 64,
  parameter int unsigned W_MAX     = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               pre_spike,
  input  logic               post_spike,
  input  logic               wload,
  input  logic [W_WIDTH-1:0] wdata,
  output logic [W_WIDTH-1:0] weight,
  output logic               upd_valid,
  output logic               upd_ltp,
  output logic [T_WIDTH-1:0] dt,
  output logic               busy
);

  localparam logic [T_WIDTH-1:0] WIN    = T_WIDTH'(WINDOW);
  localparam logic [W_WIDTH-1:0] A_P    = W_WIDTH'(A_PLUS);
  localparam logic [W_WIDTH-1:0] A_M    = W_WIDTH'(A_MINUS);
  localparam logic [W_WIDTH-1:0] W_RST  = W_WIDTH'(W_INIT);
  localparam logic [W_WIDTH:0]   W_TOP  = (W_WIDTH+1)'(W_MAX);

  typedef enum logic [1:0] {IDLE, CALC, APPLY} state_t;

  state_t              state_q, state_d;
  logic [T_WIDTH-1:0]  t_pre_q, t_pre_d;
  logic [T_WIDTH-1:0]  t_post_q, t_post_d;
  logic [T_WIDTH-1:0]  dt_q, dt_d;
  logic                ltp_q, ltp_d;
  logic [W_WIDTH-1:0]  delta_q, delta_d;
  logic [W_WIDTH-1:0]  weight_q, weight_d;
  logic                upd_valid_q, upd_valid_d;
  logic                upd_ltp_q, upd_ltp_d;
  logic [31:0]         shift_w;
  logic [W_WIDTH:0]    sum_w;
  logic [W_WIDTH:0]    diff_w;

  // Spike timers: reload on spike, otherwise count up and hold at the window edge
  always_comb begin
    t_pre_d  = pre_spike  ? '0 : ((t_pre_q  == WIN) ? t_pre_q  : t_pre_q  + 1'b1);
    t_post_d = post_spike ? '0 : ((t_post_q == WIN) ? t_post_q : t_post_q + 1'b1);
  end

  // Next-state, delta and weight computation for the three-step update sequence
  always_comb begin
    state_d     = state_q;
    dt_d        = dt_q;
    ltp_d       = ltp_q;
    delta_d     = delta_q;
    weight_d    = weight_q;
    upd_valid_d = 1'b0;
    upd_ltp_d   = upd_ltp_q;
    shift_w     = 32'(dt_q >> TAU_SHIFT);
    sum_w       = {1'b0, weight_q} + {1'b0, delta_q};
    diff_w      = {1'b0, weight_q} - {1'b0, delta_q};
    case (state_q)
      IDLE: begin
        if (en && post_spike && !pre_spike && (t_pre_q < WIN)) begin
          dt_d    = t_pre_q + 1'b1;
          ltp_d   = 1'b1;
          state_d = CALC;
        end else if (en && pre_spike && !post_spike && (t_post_q < WIN)) begin
          dt_d    = t_post_q + 1'b1;
          ltp_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (shift_w >= W_WIDTH) delta_d = '0;
        else                    delta_d = (ltp_q ? A_P : A_M) >> shift_w;
        state_d = APPLY;
      end
      APPLY: begin
        if (!wload) begin
          if (ltp_q) weight_d = (sum_w > W_TOP) ? W_TOP[W_WIDTH-1:0] : sum_w[W_WIDTH-1:0];
          else       weight_d = diff_w[W_WIDTH] ? '0 : diff_w[W_WIDTH-1:0];
          upd_valid_d = 1'b1;
          upd_ltp_d   = ltp_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Configuration load overrides any STDP update in the same cycle
    if (wload) weight_d = wdata;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_pre_q     <= WIN;
      t_post_q    <= WIN;
      dt_q        <= '0;
      ltp_q       <= 1'b0;
      delta_q     <= '0;
      weight_q    <= W_RST;
      upd_valid_q <= 1'b0;
      upd_ltp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_pre_q     <= t_pre_d;
      t_post_q    <= t_post_d;
      dt_q        <= dt_d;
      ltp_q       <= ltp_d;
      delta_q     <= delta_d;
      weight_q    <= weight_d;
      upd_valid_q <= upd_valid_d;
      upd_ltp_q   <= upd_ltp_d;
    end
  end

  assign weight    = weight_q;
  assign upd_valid = upd_valid_q;
  assign upd_ltp   = upd_ltp_q;
  assign dt        = dt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_stdp_scheduler.sv
// Directed self-checking bench for stdp_scheduler.
module tb_stdp_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       pre_spike = 1'b0;
  logic       post_spike = 1'b0;
  logic       wload = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] weight;
  logic       upd_valid;
  logic       upd_ltp;
  logic [3:0] dt;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  stdp_scheduler #(
    .W_WIDTH(8), .T_WIDTH(4), .WINDOW(15), .A_PLUS(16), .A_MINUS(16),
    .TAU_SHIFT(2), .W_INIT(64), .W_MAX(255)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .post_spike(post_spike),
    .wload(wload), .wdata(wdata), .weight(weight), .upd_valid(upd_valid),
    .upd_ltp(upd_ltp), .dt(dt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (upd_valid) p++;
    end
  endtask

  task automatic load_weight(input logic [7:0] v);
    wload = 1'b1; wdata = v;
    tick();
    wload = 1'b0;
  endtask

  // First spike, gap-1 quiet cycles, second spike; returns just after edge E0
  task automatic pair(input bit pre_first, input int gap);
    if (pre_first) pre_spike = 1'b1; else post_spike = 1'b1;
    tick();
    pre_spike = 1'b0; post_spike = 1'b0;
    idle(gap - 1);
    if (pre_first) post_spike = 1'b1; else pre_spike = 1'b1;
    tick();
    pre_spike = 1'b0; post_spike = 1'b0;
  endtask

  task automatic test_reset();
    int p;
    rst = 1'b1;
    idle(2);
    n_cmp++; if (weight !== 8'd64) begin n_fail++; $display("FAIL reset_weight got %0d want 64", weight); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid got %b want 0", upd_valid); end
    n_cmp++; if (dt !== 4'd0) begin n_fail++; $display("FAIL reset_dt got %0d want 0", dt); end
    #2 rst = 1'b0;
    tick();
    pre_spike = 1'b1;
    tick();
    pre_spike = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_pre_only_busy got %b want 0", busy); end
    count_pulses(5, p);
    n_cmp++; if (p !== 0) begin n_fail++; $display("FAIL reset_pre_only_pulses got %0d want 0", p); end
    idle(16);
  endtask

  task automatic test_ltp();
    load_weight(8'd64);
    pair(1'b1, 3);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ltp_busy_e0 got %b want 1", busy); end
    n_cmp++; if (dt !== 4'd3) begin n_fail++; $display("FAIL ltp_dt got %0d want 3", dt); end
    tick();
    n_cmp++; if (weight !== 8'd64 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL ltp_e1 weight %0d valid %b want 64/0", weight, upd_valid); end
    tick();
    n_cmp++; if (weight !== 8'd80) begin n_fail++; $display("FAIL ltp_weight got %0d want 80", weight); end
    n_cmp++; if (upd_valid !== 1'b1 || upd_ltp !== 1'b1) begin n_fail++; $display("FAIL ltp_pulse valid %b ltp %b want 1/1", upd_valid, upd_ltp); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ltp_busy_e2 got %b want 0", busy); end
    tick();
    n_cmp++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL ltp_pulse_width got %b want 0", upd_valid); end
    idle(16);
  endtask

  task automatic test_ltd_decay();
    load_weight(8'd64);
    pair(1'b0, 8);
    n_cmp++; if (dt !== 4'd8) begin n_fail++; $display("FAIL ltd_dt got %0d want 8", dt); end
    idle(2);
    n_cmp++; if (weight !== 8'd60) begin n_fail++; $display("FAIL ltd_weight got %0d want 60", weight); end
    n_cmp++; if (upd_valid !== 1'b1 || upd_ltp !== 1'b0) begin n_fail++; $display("FAIL ltd_pulse valid %b ltp %b want 1/0", upd_valid, upd_ltp); end
    idle(16);
  endtask

  task automatic test_saturation();
    load_weight(8'd250);
    pair(1'b1, 1);
    idle(2);
    n_cmp++; if (weight !== 8'd255) begin n_fail++; $display("FAIL sat_high got %0d want 255", weight); end
    idle(16);
    load_weight(8'd3);
    pair(1'b0, 1);
    idle(2);
    n_cmp++; if (weight !== 8'd0) begin n_fail++; $display("FAIL sat_low got %0d want 0", weight); end
    idle(16);
  endtask

  task automatic test_edges();
    int p;
    load_weight(8'd64);
    pre_spike = 1'b1; post_spike = 1'b1;
    tick();
    pre_spike = 1'b0; post_spike = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy got %b want 0", busy); end
    count_pulses(5, p);
    n_cmp++; if (p !== 0) begin n_fail++; $display("FAIL simul_pulses got %0d want 0", p); end
    idle(16);
    // Timer at WINDOW when post arrives: outside the pairing window
    pair(1'b1, 16);
    count_pulses(5, p);
    n_cmp++; if (p !== 0 || weight !== 8'd64) begin n_fail++; $display("FAIL window_out pulses %0d weight %0d want 0/64", p, weight); end
    idle(16);
    // Timer one below WINDOW: last valid pairing, dt=15, delta=16>>3=2
    pair(1'b1, 15);
    n_cmp++; if (dt !== 4'd15) begin n_fail++; $display("FAIL window_edge_dt got %0d want 15", dt); end
    idle(2);
    n_cmp++; if (weight !== 8'd66 || upd_valid !== 1'b1) begin n_fail++; $display("FAIL window_edge weight %0d valid %b want 66/1", weight, upd_valid); end
    idle(16);
  endtask

  task automatic test_busy_spike();
    int p;
    load_weight(8'd64);
    pair(1'b1, 3);
    pre_spike = 1'b1;
    tick();
    pre_spike = 1'b0;
    post_spike = 1'b1;
    tick();
    post_spike = 1'b0;
    n_cmp++; if (weight !== 8'd80 || upd_valid !== 1'b1) begin n_fail++; $display("FAIL busy_first weight %0d valid %b want 80/1", weight, upd_valid); end
    count_pulses(6, p);
    n_cmp++; if (p !== 0 || weight !== 8'd80) begin n_fail++; $display("FAIL busy_second pulses %0d weight %0d want 0/80", p, weight); end
    idle(16);
  endtask

  task automatic test_control();
    int p;
    // wload coinciding with APPLY
    load_weight(8'd64);
    pair(1'b1, 3);
    tick();
    wload = 1'b1; wdata = 8'd100;
    tick();
    wload = 1'b0;
    n_cmp++; if (weight !== 8'd100 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL wload_apply weight %0d valid %b want 100/0", weight, upd_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wload_apply_busy got %b want 0", busy); end
    count_pulses(4, p);
    n_cmp++; if (p !== 0) begin n_fail++; $display("FAIL wload_apply_pulses got %0d want 0", p); end
    idle(16);
    // Learning disabled
    load_weight(8'd64);
    en = 1'b0;
    pair(1'b1, 3);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en0_busy got %b want 0", busy); end
    count_pulses(4, p);
    n_cmp++; if (p !== 0 || weight !== 8'd64) begin n_fail++; $display("FAIL en0_update pulses %0d weight %0d want 0/64", p, weight); end
    en = 1'b1;
    idle(16);
    // en dropping mid-operation does not cancel the update
    pair(1'b1, 3);
    en = 1'b0;
    idle(2);
    n_cmp++; if (weight !== 8'd80 || upd_valid !== 1'b1) begin n_fail++; $display("FAIL en_fall weight %0d valid %b want 80/1", weight, upd_valid); end
    en = 1'b1;
    idle(16);
    // Reset while in CALC
    load_weight(8'd100);
    pair(1'b1, 3);
    rst = 1'b1;
    #1;
    n_cmp++; if (weight !== 8'd64 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_calc weight %0d busy %b want 64/0", weight, busy); end
    n_cmp++; if (dt !== 4'd0) begin n_fail++; $display("FAIL rst_calc_dt got %0d want 0", dt); end
    tick();
    #2 rst = 1'b0;
    count_pulses(5, p);
    n_cmp++; if (p !== 0 || weight !== 8'd64) begin n_fail++; $display("FAIL rst_calc_lost pulses %0d weight %0d want 0/64", p, weight); end
  endtask

  initial begin
    test_reset();
    test_ltp();
    test_ltd_decay();
    test_saturation();
    test_edges();
    test_busy_spike();
    test_control();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
